pipe_buffer: RTL and testbench

Parametrised elastic pipeline register for the five-stage processor, replacing the fixed always-enabled inter-stage buffers between fetch, decode, execute, memory and write-back. It carries a W-bit payload through DEPTH stages. Each stage has a valid/ready handshake, a skid entry so ready is registered, a synchronous flush for branch/hazard squash, and a live occupancy count. An optional saturating stall counter supports performance debug.

---
 rtl/pipe_buffer_if.sv | 24 ++
 rtl/pipe_buffer.sv | 111 +++++++++++
 tb/tb_pipe_buffer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_buffer_if.sv
// Valid/ready handshake bundle between an upstream producer, the elastic
// pipeline buffer and its downstream consumer.
interface pipe_buffer_if #(
    parameter int W = 16
);
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready;

    // Buffer side of the bundle
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

    // Producer/consumer side of the bundle
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipe_buffer.sv
// Elastic DEPTH-stage pipeline register with per-stage skid entry and flush.
// Optional stall statistics counter enabled by defining PIPE_BUF_STATS_EN.
module pipe_buffer #(
    parameter int W     = 16,
    parameter int DEPTH = 1,
    parameter int CW    = $clog2(2*DEPTH+1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    pipe_buffer_if.slave     bus,
    output logic [CW-1:0]    count,
    output logic [15:0]      stall_cnt
);

    logic [DEPTH-1:0] r_vm;
    logic [DEPTH-1:0] r_vs;
    logic [W-1:0]     r_dm [DEPTH];
    logic [W-1:0]     r_ds [DEPTH];

    logic [DEPTH-1:0] w_up_v;
    logic [DEPTH-1:0] w_dn_r;
    logic [W-1:0]     w_up_d [DEPTH];
    logic [DEPTH-1:0] w_take;
    logic [DEPTH-1:0] w_pop;
    logic             w_in_ready;
    logic [CW-1:0]    w_count;

    // Stage k is fed by stage k-1's main entry; its downstream ready is the
    // next stage's registered skid-empty flag, so ready never chains combinationally.
    always_comb begin
        w_up_v    = {DEPTH{1'b0}};
        w_dn_r    = {DEPTH{1'b0}};
        for (int k = 0; k < DEPTH; k++) begin
            w_up_d[k] = {W{1'b0}};
        end
        w_up_v[0] = bus.in_valid;
        w_up_d[0] = bus.in_data;
        for (int k = 1; k < DEPTH; k++) begin
            w_up_v[k] = r_vm[k-1];
            w_up_d[k] = r_dm[k-1];
        end
        w_dn_r[DEPTH-1] = bus.out_ready;
        for (int k = 0; k < DEPTH-1; k++) begin
            w_dn_r[k] = !r_vs[k+1];
        end
    end

    assign w_take = w_up_v & ~r_vs;
    assign w_pop  = r_vm & w_dn_r;

    // Per-stage main/skid entry update
    always_ff @(posedge clk) begin
        for (int k = 0; k < DEPTH; k++) begin
            if (rst) begin
                r_vm[k] <= 1'b0;
                r_vs[k] <= 1'b0;
                r_dm[k] <= {W{1'b0}};
                r_ds[k] <= {W{1'b0}};
            end else if (flush) begin
                r_vm[k] <= 1'b0;
                r_vs[k] <= 1'b0;
            end else if (r_vs[k]) begin
                if (w_pop[k]) begin
                    r_dm[k] <= r_ds[k];
                    r_vs[k] <= 1'b0;
                end
            end else if (!r_vm[k] || w_pop[k]) begin
                r_vm[k] <= w_take[k];
                if (w_take[k]) begin
                    r_dm[k] <= w_up_d[k];
                end
            end else if (w_take[k]) begin
                r_ds[k] <= w_up_d[k];
                r_vs[k] <= 1'b1;
            end
        end
    end

    // Occupancy is the population count of all valid flags
    always_comb begin
        w_count = {CW{1'b0}};
        for (int k = 0; k < DEPTH; k++) begin
            w_count = w_count + CW'(r_vm[k]) + CW'(r_vs[k]);
        end
    end

    assign w_in_ready    = !r_vs[0] && !flush;
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_vm[DEPTH-1] && !flush;
    assign bus.out_data  = r_dm[DEPTH-1];
    assign count         = w_count;

`ifdef PIPE_BUF_STATS_EN
    logic [15:0] r_stall_cnt;

    // Saturating count of cycles where upstream offered data that was refused
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= 16'h0000;
        end else if (bus.in_valid && !w_in_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'h0001;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_buffer.sv
// Self-checking bench for pipe_buffer: each stage is modelled as a two-slot
// queue whose ready is "fewer than two held"; outputs are compared every cycle.
module tb_pipe_buffer;
    localparam int W  = 16;
    localparam int D  = 3;
    localparam int CW = $clog2(2*D+1);

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic [CW-1:0] count;
    logic [15:0]   stall_cnt;

    pipe_buffer_if #(.W(W)) bus ();

    pipe_buffer #(.W(W), .DEPTH(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .bus       (bus),
        .count     (count),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    int     total  = 0;
    int     bad    = 0;
    bit     chk_en = 1'b0;

    // Reference model: per-stage queue contents and sizes, stall counter
    logic [W-1:0] md [D][2];
    int           msz [D];
    int           m_stall = 0;
    bit           rdy [D];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic m_pop(input int k);
        md[k][0] = md[k][1];
        msz[k]   = msz[k] - 1;
    endtask

    task automatic m_push(input int k, input logic [W-1:0] v);
        md[k][msz[k]] = v;
        msz[k]        = msz[k] + 1;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < D; k++) msz[k] = 0;
            m_stall = 0;
        end else begin
            for (int k = 0; k < D; k++) rdy[k] = (msz[k] < 2);
`ifdef PIPE_BUF_STATS_EN
            if (bus.in_valid && !(rdy[0] && !flush) && m_stall < 65535) m_stall++;
`endif
            if (flush) begin
                for (int k = 0; k < D; k++) msz[k] = 0;
            end else begin
                if (msz[D-1] > 0 && bus.out_ready) m_pop(D-1);
                for (int k = D-1; k >= 1; k--) begin
                    if (rdy[k] && msz[k-1] > 0) begin
                        m_push(k, md[k-1][0]);
                        m_pop(k-1);
                    end
                end
                if (bus.in_valid && rdy[0]) m_push(0, bus.in_data);
            end
        end
    end

    int n_held;
    always @(negedge clk) begin
        if (chk_en) begin
            n_held = 0;
            for (int k = 0; k < D; k++) n_held += msz[k];
            chk("in_ready", bus.in_ready, (msz[0] < 2) && !flush);
            chk("out_valid", bus.out_valid, (msz[D-1] > 0) && !flush);
            if (msz[D-1] > 0 && !flush) chk("out_data", bus.out_data, md[D-1][0]);
            chk("count", count, n_held);
            chk("stall_cnt", stall_cnt, m_stall);
        end
    end

    task automatic set(input bit v, input logic [W-1:0] d, input bit o, input bit f, input bit r);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = o;
        flush         = f;
        rst           = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int acc;

    initial begin
        set(1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b1);
        tick();
        chk_en = 1'b1;
        set(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        #1;
        chk("rst_count", count, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_data", bus.out_data, 16'h0000);
        chk("rst_stall", stall_cnt, 16'h0000);

        // Streaming: 1..8 back to back, first output after the third edge
        for (int i = 1; i <= 8; i++) begin
            set(1'b1, 16'(i), 1'b1, 1'b0, 1'b0);
            tick();
            if (i < 3) chk("lat_early", bus.out_valid, 0);
            else begin
                chk("stream_valid", bus.out_valid, 1);
                chk("stream_data", bus.out_data, i - 2);
            end
        end
        for (int j = 1; j <= 3; j++) begin
            set(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
            tick();
            if (j <= 2) chk("stream_tail", bus.out_data, 6 + j);
            else chk("stream_empty", count, 0);
        end

        // Backpressure: capacity is 2*D entries
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            set(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0, 1'b0);
            #1;
            if (bus.in_ready) acc++;
            tick();
        end
        chk("bp_accepts", acc, 2*D);
        chk("bp_in_ready", bus.in_ready, 0);
        chk("bp_count", count, 2*D);
        set(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        for (int j = 0; j < 2*D; j++) begin
            #1;
            chk("drain_valid", bus.out_valid, 1);
            chk("drain_data", bus.out_data, 16'h0100 + 16'(j));
            tick();
        end
        chk("drain_count", count, 0);

        // Flush with three entries held
        for (int i = 0; i < 3; i++) begin
            set(1'b1, 16'h0010 + 16'(i), 1'b0, 1'b0, 1'b0);
            tick();
        end
        chk("pre_flush_count", count, 3);
        set(1'b1, 16'h00AA, 1'b1, 1'b1, 1'b0);
        #1;
        chk("flush_in_ready", bus.in_ready, 0);
        chk("flush_out_valid", bus.out_valid, 0);
        tick();
        set(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        #1;
        chk("post_flush_count", count, 0);
        for (int j = 0; j < 4; j++) begin
            tick();
            chk("post_flush_no_out", bus.out_valid, 0);
        end

        // Stall statistics
        set(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 2*D; i++) begin
            set(1'b1, 16'h0200 + 16'(i), 1'b0, 1'b0, 1'b0);
            tick();
        end
        chk("full_count", count, 2*D);
        chk("stall_start", stall_cnt, 16'h0000);
        set(1'b1, 16'h0300, 1'b0, 1'b0, 1'b0);
        repeat (10) tick();
`ifdef PIPE_BUF_STATS_EN
        chk("stall_ten", stall_cnt, 16'd10);
        repeat (65530) tick();
        chk("stall_sat", stall_cnt, 16'hFFFF);
`else
        chk("stall_off", stall_cnt, 16'h0000);
`endif

        // Mid-stream reset with a pop offered in the reset cycle
        set(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        tick();
        set(1'b1, 16'h0001, 1'b0, 1'b0, 1'b0);
        tick();
        set(1'b1, 16'h0002, 1'b0, 1'b0, 1'b0);
        tick();
        chk("mid_pre_count", count, 2);
        set(1'b1, 16'h0003, 1'b1, 1'b0, 1'b1);
        tick();
        set(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        #1;
        chk("mid_rst_count", count, 0);
        chk("mid_rst_valid", bus.out_valid, 0);
        chk("mid_rst_stall", stall_cnt, 16'h0000);

        // Randomized traffic with occasional flush and reset
        repeat (3000) begin
            set($urandom_range(0, 9) < 7, 16'($urandom), $urandom_range(0, 9) < 6,
                $urandom_range(0, 49) == 0, $urandom_range(0, 199) == 0);
            tick();
        end

        set(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
